apple_slot_host: RTL and testbench

Apple II slot-bus initiator for bench and bring-up use. It generates PHI1/PHI0 from C7M and runs 6502-style bus cycles on request from a command port. Slot selects (/DEVSEL, /IOSEL, /IOSTRB) are decoded from the address for a configured slot. It sits on the host side of the slot connector and drives our peripheral-card CPLDs exactly as the motherboard does.

---
 rtl/slot_host_pkg.sv | 25 ++
 rtl/slot_host_phase.sv | 41 ++++
 rtl/apple_slot_host.sv | 198 +++++++++++++++++++
 tb/tb_apple_slot_host.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_host_pkg.sv
// Shared types, phase constants and slot-select decode for the Apple II slot host.
package slot_host_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam logic [2:0] T_LAST      = 3'd6;
  localparam logic [2:0] PHI0_FIRST  = 3'd3;
  localparam logic [2:0] DRIVE_FIRST = 3'd4;

  // Returns active-high {devsel, iosel, iostrb} for a bus address in the given slot.
  function automatic logic [2:0] sel_decode(input logic [15:0] addr, input logic [2:0] slot);
    logic devsel;
    logic iosel;
    logic iostrb;
    devsel = (addr[15:4] == (12'hC08 + {9'd0, slot}));
    iosel  = (addr[15:8] == (8'hC0 + {5'd0, slot}));
    iostrb = (addr[15:11] == 5'b11001);
    return {devsel, iosel, iostrb};
  endfunction

endpackage

// File: rtl/slot_host_phase.sv
// Free-running 7-phase C7M divider producing registered PHI1/PHI0 and the T6 strobe.
module slot_host_phase
  import slot_host_pkg::*;
(
  input  logic       C7M,
  input  logic       nRES,
  output logic [2:0] t_o,
  output logic [2:0] t_nxt_o,
  output logic       t_last_o,
  output logic       PHI1,
  output logic       PHI0
);

  logic [2:0] t_q;
  logic [2:0] t_d;
  logic       phi1_q;
  logic       phi0_q;

  always_comb begin
    t_d = (t_q == T_LAST) ? 3'd0 : t_q + 3'd1;
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      t_q    <= 3'd0;
      phi1_q <= 1'b1;
      phi0_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      phi1_q <= (t_d < PHI0_FIRST);
      phi0_q <= (t_d >= PHI0_FIRST);
    end
  end

  assign t_o      = t_q;
  assign t_nxt_o  = t_d;
  assign t_last_o = (t_q == T_LAST);
  assign PHI1     = phi1_q;
  assign PHI0     = phi0_q;

endmodule

// File: rtl/apple_slot_host.sv
// Apple II slot-bus initiator: reset sequencing, idle/command bus cycles, selects and D drive.
// Optional burst mode (cmd_len+1 beats per command) is enabled with SLOT_HOST_BURST_EN.
//
// state     | meaning
// ST_RESET  | nRESout held low for RES_CYCLES bus cycles
// ST_IDLE   | idle reads at $0000, command accepted in T6
// ST_ACTIVE | one command beat per bus cycle
module apple_slot_host
  import slot_host_pkg::*;
#(
  parameter int SLOT       = 7,
  parameter int RES_CYCLES = 4
)
(
  input  logic        C7M,
  input  logic        nRES,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_last,
  output logic        rsp_inh,
  output logic        PHI1,
  output logic        PHI0,
  output logic [15:0] A,
  output logic        nWE,
  output logic        nDEVSEL,
  output logic        nIOSEL,
  output logic        nIOSTRB,
  input  logic        nINH,
  inout  wire  [7:0]  D,
  output logic        nRESout
);

  localparam logic [2:0] SLOT_L   = 3'(SLOT);
  localparam logic [7:0] RES_INIT = 8'(RES_CYCLES - 1);

  logic [2:0]  t_cur;
  logic [2:0]  t_nxt;
  logic        t_last;

  state_e      state_q, state_d;
  logic [7:0]  res_cnt_q, res_cnt_d;
  logic        nres_out_q, nres_out_d;
  logic [15:0] a_q, a_d;
  logic        nwe_q, nwe_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [2:0]  nsel_q, nsel_d;
  logic        de_q, de_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_last_q, rsp_last_d;
  logic        rsp_inh_q, rsp_inh_d;
  logic        final_beat;
  logic        accept;

  slot_host_phase u_phase (
    .C7M      (C7M),
    .nRES     (nRES),
    .t_o      (t_cur),
    .t_nxt_o  (t_nxt),
    .t_last_o (t_last),
    .PHI1     (PHI1),
    .PHI0     (PHI0)
  );

  assign cmd_ready = t_last && ((state_q == ST_IDLE) || ((state_q == ST_ACTIVE) && final_beat));
  assign accept    = cmd_valid && cmd_ready;

`ifdef SLOT_HOST_BURST_EN
  // Remaining beats after the current one; all beats reuse the captured address.
  logic [7:0] beats_q, beats_d;

  always_comb begin
    beats_d = beats_q;
    if (t_last) begin
      if (accept)
        beats_d = cmd_len;
      else if ((state_q == ST_ACTIVE) && !final_beat)
        beats_d = beats_q - 8'd1;
    end
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) beats_q <= 8'd0;
    else       beats_q <= beats_d;
  end

  assign final_beat = (beats_q == 8'd0);
`else
  logic unused_len;
  assign unused_len = ^cmd_len;
  assign final_beat = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    res_cnt_d   = res_cnt_q;
    nres_out_d  = nres_out_q;
    a_d         = a_q;
    nwe_d       = nwe_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 8'h00;
    rsp_last_d  = 1'b0;
    rsp_inh_d   = 1'b0;
    if (t_last) begin
      case (state_q)
        ST_RESET: begin
          if (res_cnt_q == 8'd0) begin
            state_d    = ST_IDLE;
            nres_out_d = 1'b1;
          end else begin
            res_cnt_d = res_cnt_q - 8'd1;
          end
        end
        ST_ACTIVE: begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = nwe_q ? D : 8'h00;
          rsp_last_d  = final_beat;
          rsp_inh_d   = ~nINH;
        end
        default: ;
      endcase
      if (accept) begin
        state_d = ST_ACTIVE;
        a_d     = cmd_addr;
        nwe_d   = ~cmd_we;
        wdata_d = cmd_wdata;
      end else if ((state_q == ST_IDLE) || ((state_q == ST_ACTIVE) && final_beat)) begin
        state_d = ST_IDLE;
        a_d     = 16'h0000;
        nwe_d   = 1'b1;
      end
    end
  end

  // Selects and D enable are flopped from the next phase so they change only on clock edges.
  always_comb begin
    nsel_d = 3'b111;
    de_d   = 1'b0;
    if (state_q == ST_ACTIVE) begin
      if (t_nxt >= PHI0_FIRST)
        nsel_d = ~sel_decode(a_q, SLOT_L);
      de_d = !nwe_q && (t_nxt >= DRIVE_FIRST);
    end
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      state_q     <= ST_RESET;
      res_cnt_q   <= RES_INIT;
      nres_out_q  <= 1'b0;
      a_q         <= 16'h0000;
      nwe_q       <= 1'b1;
      wdata_q     <= 8'h00;
      nsel_q      <= 3'b111;
      de_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_last_q  <= 1'b0;
      rsp_inh_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_cnt_q   <= res_cnt_d;
      nres_out_q  <= nres_out_d;
      a_q         <= a_d;
      nwe_q       <= nwe_d;
      wdata_q     <= wdata_d;
      nsel_q      <= nsel_d;
      de_q        <= de_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_last_q  <= rsp_last_d;
      rsp_inh_q   <= rsp_inh_d;
    end
  end

  assign A         = a_q;
  assign nWE       = nwe_q;
  assign nDEVSEL   = nsel_q[2];
  assign nIOSEL    = nsel_q[1];
  assign nIOSTRB   = nsel_q[0];
  assign D         = de_q ? wdata_q : 8'hzz;
  assign nRESout   = nres_out_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_inh   = rsp_inh_q;

  logic unused_t;
  assign unused_t = ^t_cur;

endmodule

// File: tb/tb_apple_slot_host.sv
// Self-checking bench for apple_slot_host with a card model on D/nINH.
module tb_apple_slot_host;

  localparam int SLOT       = 7;
  localparam int RES_CYCLES = 4;

  logic        C7M;
  logic        nRES;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic [7:0]  cmd_len;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_last;
  logic        rsp_inh;
  logic        PHI1, PHI0;
  logic [15:0] A;
  logic        nWE;
  logic        nDEVSEL, nIOSEL, nIOSTRB;
  logic        nINH;
  wire  [7:0]  D;
  logic        nRESout;

  apple_slot_host #(.SLOT(SLOT), .RES_CYCLES(RES_CYCLES)) dut (
    .C7M(C7M), .nRES(nRES),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .rsp_inh(rsp_inh),
    .PHI1(PHI1), .PHI0(PHI0), .A(A), .nWE(nWE),
    .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB),
    .nINH(nINH), .D(D), .nRESout(nRESout)
  );

  // Card model drives D during PHI0 of read cycles.
  logic       card_on;
  logic [7:0] card_val;
  assign D = (card_on && nWE && PHI0) ? card_val : 8'hzz;

  initial C7M = 1'b0;
  always #5 C7M = ~C7M;

  int edges;
  always @(posedge C7M or negedge nRES) begin
    if (!nRES) edges <= 0;
    else       edges <= edges + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Observations from the last run_cmd
  logic        got_ready;
  logic [15:0] oa   [7];
  logic        onwe [7];
  logic [2:0]  osel [7];
  logic [7:0]  od   [7];
  int          rn;
  int          redge [8];
  logic [7:0]  rdat  [8];
  logic        rlast [8];
  logic        rinh  [8];
  int          ovl;

  function automatic logic [2:0] exp_sel(input logic [15:0] addr);
    int a, dbase, ibase;
    logic dv, io, st;
    a     = int'(addr);
    dbase = 'hC080 + 16 * SLOT;
    ibase = 'hC000 + 256 * SLOT;
    dv = (a >= dbase) && (a <= dbase + 15);
    io = (a >= ibase) && (a <= ibase + 255);
    st = (a >= 'hC800) && (a <= 'hCFFF);
    return {dv, io, st};
  endfunction

  function automatic int exp_beats(input logic [7:0] len);
`ifdef SLOT_HOST_BURST_EN
    return int'(len) + 1;
`else
    return (len == 8'd0) ? 1 : 1;
`endif
  endfunction

  task automatic run_cmd(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         input logic [7:0] len, input logic [7:0] cd, input logic inh);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge C7M);
      if (edges % 7 == 6) found = 1'b1;
    end
    got_ready = found && cmd_ready;
    card_val  = cd;
    nINH      = ~inh;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_len   = len;
    @(posedge C7M);
    #1;
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom_range(0, 1));
    cmd_addr  = 16'($urandom);
    cmd_wdata = 8'($urandom);
    cmd_len   = 8'($urandom);
    rn  = 0;
    ovl = 0;
    for (int j = 0; j < 38; j++) begin
      @(negedge C7M);
      if (j < 7) begin
        oa[j]   = A;
        onwe[j] = nWE;
        osel[j] = {~nDEVSEL, ~nIOSEL, ~nIOSTRB};
        od[j]   = D;
      end
      if (PHI1 && !(nDEVSEL && nIOSEL && nIOSTRB)) ovl++;
      if (rsp_valid) begin
        if (rn < 8) begin
          redge[rn] = j;
          rdat[rn]  = rsp_rdata;
          rlast[rn] = rsp_last;
          rinh[rn]  = rsp_inh;
        end
        rn++;
      end
    end
  endtask

  task automatic test_reset();
    int first_hi, first_rdy, phase_bad;
    nRES = 1'b0;
    repeat (3) @(negedge C7M);
    n_cmp++;
    if ({PHI1, PHI0, A, nWE, nDEVSEL, nIOSEL, nIOSTRB, nRESout, cmd_ready} !== {1'b1, 1'b0, 16'h0000, 1'b1, 3'b111, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_bus: got PHI1=%b PHI0=%b A=%h nWE=%b sel=%b%b%b nRESout=%b rdy=%b, want 1 0 0000 1 111 0 0",
               PHI1, PHI0, A, nWE, nDEVSEL, nIOSEL, nIOSTRB, nRESout, cmd_ready);
    end
    n_cmp++;
    if ({rsp_valid, rsp_rdata, rsp_last, rsp_inh} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_rsp: got v=%b d=%h l=%b i=%b, want all 0", rsp_valid, rsp_rdata, rsp_last, rsp_inh);
    end
    nRES = 1'b1;
    first_hi = -1; first_rdy = -1; phase_bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge C7M);
      if (nRESout && first_hi < 0) first_hi = edges;
      if (cmd_ready && first_rdy < 0) first_rdy = edges;
      if (PHI1 !== ((edges % 7) < 3) || PHI0 !== ~PHI1) phase_bad++;
    end
    n_cmp++;
    if (first_hi != 7 * RES_CYCLES) begin
      n_bad++;
      $display("FAIL nresout_release: nRESout rose after %0d clocks, want %0d", first_hi, 7 * RES_CYCLES);
    end
    n_cmp++;
    if (first_rdy != 7 * RES_CYCLES + 6) begin
      n_bad++;
      $display("FAIL first_ready: at clock %0d, want %0d", first_rdy, 7 * RES_CYCLES + 6);
    end
    n_cmp++;
    if (phase_bad != 0) begin
      n_bad++;
      $display("FAIL phi_pattern: %0d bad samples, want 0", phase_bad);
    end
  endtask

  task automatic test_write_devsel();
    run_cmd(1'b1, 16'hC0F2, 8'h05, 8'd0, 8'h77, 1'b0);
    n_cmp++;
    if (got_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready: got %b want 1", got_ready); end
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (oa[k] !== 16'hC0F2 || onwe[k] !== 1'b0 || osel[k] !== ((k >= 3) ? 3'b100 : 3'b000)) begin
        n_bad++;
        $display("FAIL wr_bus_T%0d: got A=%h nWE=%b sel=%b want C0F2 0 %b", k, oa[k], onwe[k], osel[k], (k >= 3) ? 3'b100 : 3'b000);
      end
      n_cmp++;
      if ((k >= 4) ? (od[k] !== 8'h05) : (od[k] === 8'h05)) begin
        n_bad++;
        $display("FAIL wr_d_T%0d: got D=%h, want %s", k, od[k], (k >= 4) ? "05" : "not driven");
      end
    end
    n_cmp++;
    if (rn != 1 || redge[0] != 7 || rdat[0] !== 8'h00 || rlast[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_rsp: got n=%0d at=%0d d=%h last=%b want 1 7 00 1", rn, redge[0], rdat[0], rlast[0]);
    end
  endtask

  task automatic test_read_iosel();
    run_cmd(1'b0, 16'hC700, 8'h00, 8'd0, 8'hA9, 1'b0);
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (onwe[k] !== 1'b1 || osel[k] !== ((k >= 3) ? 3'b010 : 3'b000)) begin
        n_bad++;
        $display("FAIL rd_iosel_T%0d: got nWE=%b sel=%b want 1 %b", k, onwe[k], osel[k], (k >= 3) ? 3'b010 : 3'b000);
      end
    end
    n_cmp++;
    if (rn != 1 || redge[0] != 7 || rdat[0] !== 8'hA9 || rinh[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_iosel_rsp: got n=%0d at=%0d d=%h inh=%b want 1 7 a9 0", rn, redge[0], rdat[0], rinh[0]);
    end
  endtask

  task automatic test_read_strobe_nosel();
    logic inh;
    run_cmd(1'b0, 16'hCFFF, 8'h00, 8'd0, 8'h3C, 1'b0);
    n_cmp++;
    if (osel[3] !== 3'b001 || osel[6] !== 3'b001 || osel[2] !== 3'b000) begin
      n_bad++;
      $display("FAIL rd_iostrb: got T2=%b T3=%b T6=%b want 000 001 001", osel[2], osel[3], osel[6]);
    end
    for (int r = 0; r < 2; r++) begin
      inh = 1'(r);
      run_cmd(1'b0, 16'hC400, 8'h00, 8'd0, 8'($urandom), inh);
      n_cmp++;
      if ((osel[3] | osel[4] | osel[5] | osel[6]) !== 3'b000) begin
        n_bad++;
        $display("FAIL rd_nosel: got sel=%b want 000", osel[3] | osel[4] | osel[5] | osel[6]);
      end
      n_cmp++;
      if (rn != 1 || rinh[0] !== inh) begin
        n_bad++;
        $display("FAIL rd_inh: got n=%0d inh=%b want 1 %b", rn, rinh[0], inh);
      end
    end
    nINH = 1'b1;
  endtask

  task automatic test_burst();
    int nb;
    nb = exp_beats(8'd3);
    run_cmd(1'b0, 16'hC0F3, 8'h00, 8'd3, 8'h5E, 1'b0);
    n_cmp++;
    if (rn != nb) begin
      n_bad++;
      $display("FAIL burst_count: got %0d beats want %0d", rn, nb);
    end
    for (int b = 0; b < nb && b < rn && b < 8; b++) begin
      n_cmp++;
      if (redge[b] != 7 * (b + 1) || rdat[b] !== 8'h5E || rlast[b] !== (b == nb - 1)) begin
        n_bad++;
        $display("FAIL burst_beat%0d: got at=%0d d=%h last=%b want %0d 5e %b", b, redge[b], rdat[b], rlast[b], 7 * (b + 1), (b == nb - 1));
      end
    end
  endtask

  task automatic test_random();
    logic        we, inh;
    logic [15:0] addr;
    logic [7:0]  wd, cd, len;
    logic [2:0]  es;
    int          nb, bad;
    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 3))
        0:       addr = 16'(16'hC080 + 16 * SLOT + $urandom_range(0, 15));
        1:       addr = 16'(16'hC000 + 256 * SLOT + $urandom_range(0, 255));
        2:       addr = 16'(16'hC800 + $urandom_range(0, 16'h7FF));
        default: addr = 16'($urandom);
      endcase
      we  = 1'($urandom_range(0, 1));
      wd  = 8'($urandom_range(1, 255));
      cd  = 8'($urandom);
      len = 8'($urandom_range(0, 3));
      inh = 1'($urandom_range(0, 1));
      es  = exp_sel(addr);
      nb  = exp_beats(len);
      run_cmd(we, addr, wd, len, cd, inh);
      bad = 0;
      for (int k = 0; k < 7; k++) begin
        if (oa[k] !== addr || onwe[k] !== ~we || osel[k] !== ((k >= 3) ? es : 3'b000)) bad++;
        if (we && k >= 4 && od[k] !== wd) bad++;
      end
      n_cmp++;
      if (bad != 0 || ovl != 0 || got_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL rnd%0d_bus: addr=%h we=%b bad=%0d overlap=%0d ready=%b want 0 0 1", n, addr, we, bad, ovl, got_ready);
      end
      bad = (rn != nb) ? 1 : 0;
      for (int b = 0; b < nb && b < rn && b < 8; b++) begin
        if (redge[b] != 7 * (b + 1) || rdat[b] !== (we ? 8'h00 : cd) || rlast[b] !== (b == nb - 1) || rinh[b] !== inh) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_rsp: addr=%h we=%b got %0d beats want %0d, d0=%h want %h", n, addr, we, rn, nb, rdat[0], we ? 8'h00 : cd);
      end
    end
    nINH = 1'b1;
  endtask

  task automatic test_reset_midbeat();
    bit found;
    int first_hi, pulses;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge C7M);
      if (edges % 7 == 6) found = 1'b1;
    end
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'hC0F2; cmd_wdata = 8'h05; cmd_len = 8'd0;
    @(posedge C7M);
    #1 cmd_valid = 1'b0;
    repeat (6) @(negedge C7M);
    n_cmp++;
    if (D !== 8'h05 || nDEVSEL !== 1'b0 || !found) begin
      n_bad++;
      $display("FAIL mid_pre: T5 got D=%h nDEVSEL=%b want 05 0", D, nDEVSEL);
    end
    nRES = 1'b0;
    #1;
    n_cmp++;
    if (D === 8'h05 || nDEVSEL !== 1'b1 || nRESout !== 1'b0 || A !== 16'h0000 || nWE !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_async: got D=%h nDEVSEL=%b nRESout=%b A=%h nWE=%b want Z 1 0 0000 1", D, nDEVSEL, nRESout, A, nWE);
    end
    @(negedge C7M);
    nRES = 1'b1;
    first_hi = -1; pulses = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge C7M);
      if (rsp_valid) pulses++;
      if (nRESout && first_hi < 0) first_hi = edges;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL mid_norsp: got %0d responses want 0", pulses);
    end
    n_cmp++;
    if (first_hi != 7 * RES_CYCLES) begin
      n_bad++;
      $display("FAIL mid_restart: nRESout rose after %0d clocks want %0d", first_hi, 7 * RES_CYCLES);
    end
  endtask

  initial begin
    nRES = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 16'h0000;
    cmd_wdata = 8'h00; cmd_len = 8'd0; nINH = 1'b1; card_on = 1'b0; card_val = 8'h00;
    test_reset();
    card_on = 1'b1;
    test_write_devsel();
    test_read_iosel();
    test_read_strobe_nosel();
    test_burst();
    test_random();
    test_reset_midbeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
